// File: rtl/bpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bpu_pkg
// Description : Shared widths, BHT counter encodings and sequencer state
//               encodings for the branch predictor table controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bpu_pkg;

    // Default table geometry: 1024 entries indexed by PC[11:2]
    localparam int BPU_IDX_W = 10;
    localparam int BPU_TAG_W = 20;
    localparam int BPU_TGT_W = 30;

    // 2-bit saturating counter encodings
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } bpu_state_e;

    // Plain-vector views of the state encodings for the sequencer register
    localparam logic [0:0] ST_INIT = INIT;
    localparam logic [0:0] ST_RUN  = RUN;

endpackage
`default_nettype wire

// File: rtl/bpu_table_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bpu_table_ctrl_if
// Description : EX update report, combinational table read-back and table
//               write port bundled between the pipeline/table and the
//               table sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface bpu_table_ctrl_if
    import bpu_pkg::*;
#(
    parameter int IDX_W = BPU_IDX_W,
    parameter int TAG_W = BPU_TAG_W,
    parameter int TGT_W = BPU_TGT_W
);
    // EX resolution report
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic [TGT_W-1:0] upd_target;
    logic             upd_branch;
    logic             upd_taken;
    logic             upd_mispred;

    // Table read at upd_idx
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [1:0]       rd_ctr;

    // Table write port
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_widx;
    logic             tbl_wvalid;
    logic             tbl_wbranch;
    logic [TAG_W-1:0] tbl_wtag;
    logic [TGT_W-1:0] tbl_wtarget;
    logic [1:0]       tbl_wctr;

    modport master (
        output upd_valid, upd_idx, upd_tag, upd_target,
               upd_branch, upd_taken, upd_mispred,
               rd_valid, rd_tag, rd_ctr,
        input  tbl_we, tbl_widx, tbl_wvalid, tbl_wbranch,
               tbl_wtag, tbl_wtarget, tbl_wctr
    );

    modport slave (
        input  upd_valid, upd_idx, upd_tag, upd_target,
               upd_branch, upd_taken, upd_mispred,
               rd_valid, rd_tag, rd_ctr,
        output tbl_we, tbl_widx, tbl_wvalid, tbl_wbranch,
               tbl_wtag, tbl_wtarget, tbl_wctr
    );

endinterface
`default_nettype wire

// File: rtl/bpu_ctr_sat.sv
`default_nettype none
// ============================================================================
// Module      : bpu_ctr_sat
// Description : Combinational 2-bit saturating counter step. Taken moves
//               toward strongly-taken, not-taken toward strongly-not-taken.
// Revision    : 1.0 - initial release
// ============================================================================
module bpu_ctr_sat
    import bpu_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr
);

    // Step by one unless already pinned at the end in that direction
    always_comb begin
        o_ctr = i_ctr;
        if (i_taken) begin
            if (i_ctr != CTR_ST) begin
                o_ctr = i_ctr + 2'd1;
            end
        end else begin
            if (i_ctr != CTR_SNT) begin
                o_ctr = i_ctr - 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bpu_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bpu_table_ctrl
// Description : Owner of the BHT/BTB write port. Clears every entry after
//               reset and on fence.i, then converts EX resolution reports
//               into registered table writes with a one-deep forward path
//               for back-to-back updates to the same index.
// Revision    : 1.0 - initial release
// ============================================================================
module bpu_table_ctrl
    import bpu_pkg::*;
#(
    parameter int IDX_W = BPU_IDX_W,
    parameter int TAG_W = BPU_TAG_W,
    parameter int TGT_W = BPU_TGT_W
)(
    input  logic                clk,
    input  logic                rstn,
    bpu_table_ctrl_if.slave     bus,
    input  logic                flush_req,
    output logic                pred_en,
    output logic                busy,
    output logic                flush_done,
    output logic [31:0]         mispred_cnt
);

    localparam logic [IDX_W-1:0] c_last_idx = '1;

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_walk;
    logic             r_flush_done;
    logic [31:0]      r_mispred_cnt;

    // Registered write port; r_walk_wr marks a clearing write
    logic             r_we;
    logic             r_walk_wr;
    logic [IDX_W-1:0] r_widx;
    logic             r_wvalid;
    logic             r_wbranch;
    logic [TAG_W-1:0] r_wtag;
    logic [TGT_W-1:0] r_wtarget;
    logic [1:0]       r_wctr;

    logic             w_last_done;
    logic             w_walk_issue;
    logic             w_upd_accept;
    logic             w_fwd;
    logic             w_old_valid;
    logic [TAG_W-1:0] w_old_tag;
    logic [1:0]       w_old_ctr;
    logic             w_hit;
    logic [1:0]       w_sat_ctr;
    logic [1:0]       w_new_ctr;

    // The last clearing write is on the port this cycle and commits at the edge
    assign w_last_done  = (r_state == ST_INIT) && r_we && r_walk_wr && (r_widx == c_last_idx);
    // A flush cycle in INIT issues nothing so the walk restarts cleanly at 0
    assign w_walk_issue = (r_state == ST_INIT) && !flush_req && !w_last_done;
    // Flush wins over a simultaneous update
    assign w_upd_accept = (r_state == ST_RUN) && bus.upd_valid && !flush_req;

    // The pending write has not reached the table yet, so its contents
    // replace the stale read-back when it targets the same index
    assign w_fwd       = (r_state == ST_RUN) && r_we && (r_widx == bus.upd_idx);
    assign w_old_valid = w_fwd ? r_wvalid : bus.rd_valid;
    assign w_old_tag   = w_fwd ? r_wtag   : bus.rd_tag;
    assign w_old_ctr   = w_fwd ? r_wctr   : bus.rd_ctr;
    assign w_hit       = w_old_valid && (w_old_tag == bus.upd_tag);

    bpu_ctr_sat u_ctr_sat (
        .i_ctr   (w_old_ctr),
        .i_taken (bus.upd_taken),
        .o_ctr   (w_sat_ctr)
    );

    // Counter to write: non-branches pinned strongly-taken, misses allocate weak
    always_comb begin
        w_new_ctr = CTR_ST;
        if (bus.upd_branch) begin
            if (w_hit) begin
                w_new_ctr = w_sat_ctr;
            end else begin
                w_new_ctr = bus.upd_taken ? CTR_WT : CTR_WNT;
            end
        end
    end

    // Sequencer state and clearing-walk index
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_INIT;
            r_walk  <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (flush_req) begin
                        r_walk <= '0;
                    end else if (w_last_done) begin
                        r_state <= ST_RUN;
                    end else if (w_walk_issue) begin
                        r_walk <= r_walk + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (flush_req) begin
                        r_state <= ST_INIT;
                        r_walk  <= '0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_walk  <= '0;
                end
            endcase
        end
    end

    // Table write register: clearing write in INIT, update write in RUN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_we      <= 1'b0;
            r_walk_wr <= 1'b0;
            r_widx    <= '0;
            r_wvalid  <= 1'b0;
            r_wbranch <= 1'b0;
            r_wtag    <= '0;
            r_wtarget <= '0;
            r_wctr    <= CTR_SNT;
        end else begin
            r_we      <= 1'b0;
            r_walk_wr <= 1'b0;
            if (w_walk_issue) begin
                r_we      <= 1'b1;
                r_walk_wr <= 1'b1;
                r_widx    <= r_walk;
                r_wvalid  <= 1'b0;
                r_wbranch <= 1'b0;
                r_wtag    <= '0;
                r_wtarget <= '0;
                r_wctr    <= CTR_SNT;
            end else if (w_upd_accept) begin
                r_we      <= 1'b1;
                r_widx    <= bus.upd_idx;
                r_wvalid  <= 1'b1;
                r_wbranch <= bus.upd_branch;
                r_wtag    <= bus.upd_tag;
                r_wtarget <= bus.upd_target;
                r_wctr    <= w_new_ctr;
            end
        end
    end

    // One-cycle completion pulse coincident with entering RUN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= w_last_done && !flush_req;
        end
    end

    // Mispredict counter, only while predictions are live
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mispred_cnt <= '0;
        end else if ((r_state == ST_RUN) && bus.upd_valid && bus.upd_mispred) begin
            r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign bus.tbl_we      = r_we;
    assign bus.tbl_widx    = r_widx;
    assign bus.tbl_wvalid  = r_wvalid;
    assign bus.tbl_wbranch = r_wbranch;
    assign bus.tbl_wtag    = r_wtag;
    assign bus.tbl_wtarget = r_wtarget;
    assign bus.tbl_wctr    = r_wctr;

    assign pred_en     = (r_state == ST_RUN);
    assign busy        = (r_state == ST_INIT);
    assign flush_done  = r_flush_done;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire
